bus_trace_dumper: RTL and testbench

//  Parametrised trace dumper: drains snooped bus records (valid/ready, from the record async_fifo) and serialises

---
 rtl/bus_debug_pkg.sv | 47 ++++
 rtl/hex_ascii_digit.sv | 10 +
 rtl/bus_trace_dumper.sv | 204 ++++++++++++++++++++
 tb/tb_bus_trace_dumper.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_debug_pkg.sv
// Shared definitions for the bus trace dumper: record layout, ASCII constants,
// default sync byte and the dump state encoding.
package bus_debug_pkg;

  localparam logic [7:0] ASCII_SPACE       = 8'h20;
  localparam logic [7:0] ASCII_CR          = 8'h0D;
  localparam logic [7:0] ASCII_LF          = 8'h0A;
  localparam logic [7:0] ASCII_R           = 8'h52;
  localparam logic [7:0] ASCII_W           = 8'h57;
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_FILTER,
    ST_EMIT,
    ST_DONE
  } dump_state_e;

  // Record is {read_write, address, data}
  function automatic int unsigned rec_width(input int unsigned bw);
    return 2 * bw + 1;
  endfunction

  function automatic int unsigned rw_bit(input int unsigned bw);
    return 2 * bw;
  endfunction

  function automatic int unsigned addr_lsb(input int unsigned bw);
    return bw;
  endfunction

  function automatic int unsigned data_lsb(input int unsigned bw);
    return 0 * bw;
  endfunction

  // Hex line: addr digits, space, data digits, space, R/W, CR, LF
  function automatic int unsigned ascii_len(input int unsigned bw);
    return 2 * (bw / 4) + 5;
  endfunction

  // Sync byte plus the record rounded up to whole bytes
  function automatic int unsigned raw_len(input int unsigned bw);
    return (rec_width(bw) + 7) / 8 + 1;
  endfunction

endpackage

// File: rtl/hex_ascii_digit.sv
// Converts one nibble to its uppercase ASCII hex character.
module hex_ascii_digit (
  input  logic [3:0] nibble_i,
  output logic [7:0] ascii_o
);

  assign ascii_o = (nibble_i < 4'd10) ? 8'(8'h30 + 8'(nibble_i))
                                      : 8'(8'h37 + 8'(nibble_i));

endmodule

// File: rtl/bus_trace_dumper.sv
// Drains snooped bus records and serialises them as ASCII hex lines or raw
// binary frames, with address filtering, record limit and abort.
module bus_trace_dumper
  import bus_debug_pkg::*;
#(
  parameter int unsigned BITWIDTH    = 32,
  parameter int unsigned COUNT_WIDTH = 16,
  parameter logic [7:0]  SYNC_BYTE   = DEFAULT_SYNC_BYTE
) (
  input  logic                   comm_clock,
  input  logic                   reset,
  input  logic                   dump_start,
  input  logic                   dump_abort,
  input  logic                   mode_raw,
  input  logic [BITWIDTH-1:0]    filter_match,
  input  logic [BITWIDTH-1:0]    filter_mask,
  input  logic [COUNT_WIDTH-1:0] max_records,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2*BITWIDTH:0]    in_data,
  input  logic                   in_empty,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_data,
  output logic                   busy,
  output logic                   dump_end,
  output logic [COUNT_WIDTH-1:0] records_sent,
  output logic                   led
);

  localparam int unsigned REC_W     = rec_width(BITWIDTH);
  localparam int unsigned RW_BIT    = rw_bit(BITWIDTH);
  localparam int unsigned ADDR_LSB  = addr_lsb(BITWIDTH);
  localparam int unsigned DATA_LSB  = data_lsb(BITWIDTH);
  localparam int unsigned NDIG      = BITWIDTH / 4;
  localparam int unsigned ASCII_LEN = ascii_len(BITWIDTH);
  localparam int unsigned RAW_LEN   = raw_len(BITWIDTH);
  localparam int unsigned RAW_BYTES = RAW_LEN - 1;
  localparam int unsigned RAW_W     = RAW_BYTES * 8;
  localparam int unsigned PAD       = RAW_W - REC_W;
  localparam int unsigned MAX_LEN   = (ASCII_LEN > RAW_LEN) ? ASCII_LEN : RAW_LEN;
  localparam int unsigned IDX_W     = $clog2(MAX_LEN);

  dump_state_e            state_q;
  logic                   raw_q;
  logic [BITWIDTH-1:0]    match_q;
  logic [BITWIDTH-1:0]    mask_q;
  logic [COUNT_WIDTH-1:0] limit_q;
  logic                   abort_q;
  logic [REC_W-1:0]       rec_q;
  logic [IDX_W-1:0]       idx_q;
  logic                   in_ready_q;
  logic                   out_valid_q;
  logic [7:0]             out_data_q;
  logic                   busy_q;
  logic                   dump_end_q;
  logic [COUNT_WIDTH-1:0] sent_q;

  logic [BITWIDTH-1:0]    addr_c;
  logic [BITWIDTH-1:0]    data_c;
  logic                   rw_c;
  logic [RAW_W-1:0]       rec_pad_c;
  logic [IDX_W-1:0]       sel_idx_c;
  logic [IDX_W-1:0]       last_idx_c;
  logic [31:0]            sel_w;
  logic [3:0]             nib_c;
  logic [7:0]             digit_c;
  logic [7:0]             byte_c;
  logic [COUNT_WIDTH-1:0] sent_inc_c;
  logic                   pass_c;

  assign rw_c       = rec_q[RW_BIT];
  assign addr_c     = rec_q[ADDR_LSB +: BITWIDTH];
  assign data_c     = rec_q[DATA_LSB +: BITWIDTH];
  // Raw frames are MSB-aligned; the pad bits sit at the tail of the last byte
  assign rec_pad_c  = RAW_W'(rec_q) << PAD;
  assign sel_idx_c  = (state_q == ST_EMIT) ? IDX_W'(idx_q + IDX_W'(1)) : '0;
  assign last_idx_c = raw_q ? IDX_W'(RAW_LEN - 1) : IDX_W'(ASCII_LEN - 1);
  assign sel_w      = 32'(sel_idx_c);
  assign sent_inc_c = (&sent_q) ? sent_q : COUNT_WIDTH'(sent_q + 1'b1);
  assign pass_c     = ((addr_c ^ match_q) & mask_q) == '0;

  always_comb begin
    nib_c = '0;
    if (sel_w < NDIG) nib_c = 4'(addr_c >> (4 * (NDIG - 1 - sel_w)));
    else              nib_c = 4'(data_c >> (4 * (2 * NDIG - sel_w)));
  end

  hex_ascii_digit u_digit (
    .nibble_i (nib_c),
    .ascii_o  (digit_c)
  );

  // Byte presented for position sel_idx_c of the current record
  always_comb begin
    byte_c = '0;
    if (raw_q) begin
      if (sel_w == 0) byte_c = SYNC_BYTE;
      else            byte_c = 8'(rec_pad_c >> (8 * (RAW_BYTES - sel_w)));
    end else if (sel_w < NDIG || (sel_w > NDIG && sel_w <= 2 * NDIG)) begin
      byte_c = digit_c;
    end else if (sel_w == NDIG || sel_w == 2 * NDIG + 1) begin
      byte_c = ASCII_SPACE;
    end else if (sel_w == 2 * NDIG + 2) begin
      byte_c = rw_c ? ASCII_R : ASCII_W;
    end else if (sel_w == 2 * NDIG + 3) begin
      byte_c = ASCII_CR;
    end else begin
      byte_c = ASCII_LF;
    end
  end

  always_ff @(posedge comm_clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      raw_q       <= 1'b0;
      match_q     <= '0;
      mask_q      <= '0;
      limit_q     <= '0;
      abort_q     <= 1'b0;
      rec_q       <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      dump_end_q  <= 1'b0;
      sent_q      <= '0;
    end else begin
      dump_end_q <= 1'b0;
      if (busy_q && dump_abort) abort_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (dump_start) begin
            raw_q      <= mode_raw;
            match_q    <= filter_match;
            mask_q     <= filter_mask;
            limit_q    <= max_records;
            sent_q     <= '0;
            abort_q    <= 1'b0;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b1;
            state_q    <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (in_valid && in_ready_q) begin
            rec_q      <= in_data;
            in_ready_q <= 1'b0;
            state_q    <= ST_FILTER;
          end else if (in_empty || abort_q || dump_abort) begin
            in_ready_q <= 1'b0;
            dump_end_q <= 1'b1;
            state_q    <= ST_DONE;
          end
        end
        ST_FILTER: begin
          if (pass_c) begin
            out_valid_q <= 1'b1;
            out_data_q  <= byte_c;
            idx_q       <= '0;
            state_q     <= ST_EMIT;
          end else begin
            in_ready_q <= 1'b1;
            state_q    <= ST_FETCH;
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            if (idx_q == last_idx_c) begin
              out_valid_q <= 1'b0;
              sent_q      <= sent_inc_c;
              if ((limit_q != '0 && sent_inc_c == limit_q) || abort_q || dump_abort) begin
                dump_end_q <= 1'b1;
                state_q    <= ST_DONE;
              end else begin
                in_ready_q <= 1'b1;
                state_q    <= ST_FETCH;
              end
            end else begin
              idx_q      <= IDX_W'(idx_q + IDX_W'(1));
              out_data_q <= byte_c;
            end
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          abort_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign busy         = busy_q;
  assign dump_end     = dump_end_q;
  assign records_sent = sent_q;
  assign led          = busy_q;

endmodule

// File: tb/tb_bus_trace_dumper.sv
// Directed bench for bus_trace_dumper (BITWIDTH=32): ASCII, raw, filter,
// limit, backpressure, abort and reset scenarios against hand-written streams.
module tb_bus_trace_dumper;

  logic        clk;
  logic        reset;
  logic        dump_start;
  logic        dump_abort;
  logic        mode_raw;
  logic [31:0] filter_match;
  logic [31:0] filter_mask;
  logic [15:0] max_records;
  logic        in_valid;
  logic        in_ready;
  logic [64:0] in_data;
  logic        in_empty;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        busy;
  logic        dump_end;
  logic [15:0] records_sent;
  logic        led;

  bus_trace_dumper dut (
    .comm_clock   (clk),
    .reset        (reset),
    .dump_start   (dump_start),
    .dump_abort   (dump_abort),
    .mode_raw     (mode_raw),
    .filter_match (filter_match),
    .filter_mask  (filter_mask),
    .max_records  (max_records),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_empty     (in_empty),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .busy         (busy),
    .dump_end     (dump_end),
    .records_sent (records_sent),
    .led          (led)
  );

  logic [64:0] src_q[$];
  logic [7:0]  cap_q[$];
  logic [7:0]  exp_q[$];
  int          passed;
  int          total;
  int          cyc;
  int          acc_cyc;
  int          ov_cyc;
  int          end_cnt;
  int          stall_cnt;
  int          stall_err;
  bit          rdy_rand;
  bit          ov_prev;
  bit          stall_prev;
  logic [7:0]  stall_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source FIFO and sink model, driven away from the active edge
  initial forever begin
    @(negedge clk);
    in_valid  = (src_q.size() > 0);
    in_data   = in_valid ? src_q[0] : '0;
    in_empty  = !in_valid;
    out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
    if (in_valid && in_ready) begin
      if (src_q.size() > 0) void'(src_q.pop_front());
      acc_cyc = cyc;
    end
    if (out_valid && out_ready) cap_q.push_back(out_data);
    if (out_valid && !ov_prev) ov_cyc = cyc;
    if (stall_prev && out_valid && out_data !== stall_data) stall_err++;
    stall_prev = out_valid && !out_ready;
    if (stall_prev) begin
      stall_data = out_data;
      stall_cnt++;
    end
    ov_prev = out_valid;
    if (dump_end) end_cnt++;
  end

  task automatic add_line(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(8'(s[i]));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  function automatic int first_diff();
    int n;
    n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (cap_q[i] !== exp_q[i]) return i;
    if (cap_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  task automatic clear_streams();
    cap_q.delete();
    exp_q.delete();
  endtask

  // Inputs are scrambled after the start pulse so only latched settings matter
  task automatic start_dump(input logic raw, input logic [31:0] match, input logic [31:0] mask,
                            input logic [15:0] maxr, input logic with_abort);
    @(negedge clk);
    mode_raw     = raw;
    filter_match = match;
    filter_mask  = mask;
    max_records  = maxr;
    dump_start   = 1'b1;
    dump_abort   = with_abort;
    @(negedge clk);
    dump_start   = 1'b0;
    dump_abort   = 1'b0;
    mode_raw     = !raw;
    filter_match = 32'h0;
    filter_mask  = 32'hFFFF_FFFF;
    max_records  = 16'd1;
  endtask

  task automatic wait_end(input int budget, output bit ok);
    int n;
    int e0;
    n  = 0;
    e0 = end_cnt;
    ok = 1'b0;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (end_cnt != e0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passed++;
    total++; if (out_data !== 8'h00) $display("FAIL reset_out_data: got %h expected 00", out_data); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    total++; if (dump_end !== 1'b0) $display("FAIL reset_dump_end: got %b expected 0", dump_end); else passed++;
    total++; if (records_sent !== 16'd0) $display("FAIL reset_records_sent: got %0d expected 0", records_sent); else passed++;
    total++; if (led !== 1'b0) $display("FAIL reset_led: got %b expected 0", led); else passed++;
  endtask

  task automatic test_ascii();
    bit ok;
    clear_streams();
    src_q.push_back({1'b1, 32'h0010_0400, 32'hDEAD_BEEF});
    add_line("00100400 DEADBEEF R");
    start_dump(1'b0, 32'h0, 32'h0, 16'd0, 1'b0);
    total++; if (busy !== 1'b1 || led !== 1'b1) $display("FAIL ascii_busy: got busy=%b led=%b expected 1/1", busy, led); else passed++;
    wait_end(100, ok);
    total++; if (!ok) $display("FAIL ascii_end: got no dump_end expected pulse"); else passed++;
    total++; if (first_diff() >= 0) $display("FAIL ascii_stream: got %0d bytes expected %0d, first diff at %0d", cap_q.size(), exp_q.size(), first_diff()); else passed++;
    total++; if (records_sent !== 16'd1) $display("FAIL ascii_records_sent: got %0d expected 1", records_sent); else passed++;
    total++; if (ov_cyc - acc_cyc !== 2) $display("FAIL ascii_latency: got %0d expected 2", ov_cyc - acc_cyc); else passed++;
    total++; if (busy !== 1'b0 || dump_end !== 1'b0) $display("FAIL ascii_idle: got busy=%b dump_end=%b expected 0/0", busy, dump_end); else passed++;
  endtask

  task automatic test_raw();
    bit ok;
    logic [7:0] raw_exp [10];
    raw_exp = '{8'hA5, 8'h80, 8'h08, 8'h02, 8'h00, 8'h6F, 8'h56, 8'hDF, 8'h77, 8'h80};
    clear_streams();
    for (int i = 0; i < 10; i++) exp_q.push_back(raw_exp[i]);
    src_q.push_back({1'b1, 32'h0010_0400, 32'hDEAD_BEEF});
    start_dump(1'b1, 32'h0, 32'h0, 16'd0, 1'b0);
    wait_end(100, ok);
    total++; if (!ok) $display("FAIL raw_end: got no dump_end expected pulse"); else passed++;
    total++; if (first_diff() >= 0) $display("FAIL raw_stream: got %0d bytes expected %0d, first diff at %0d", cap_q.size(), exp_q.size(), first_diff()); else passed++;
    total++; if (records_sent !== 16'd1) $display("FAIL raw_records_sent: got %0d expected 1", records_sent); else passed++;
  endtask

  task automatic test_filter();
    bit ok;
    clear_streams();
    src_q.push_back({1'b0, 32'h0010_0004, 32'h0000_0001});
    src_q.push_back({1'b1, 32'h0020_0000, 32'h1234_5678});
    src_q.push_back({1'b1, 32'h0010_FFFC, 32'hCAFE_F00D});
    add_line("00100004 00000001 W");
    add_line("0010FFFC CAFEF00D R");
    start_dump(1'b0, 32'h0010_0000, 32'hFFFF_0000, 16'd0, 1'b0);
    wait_end(200, ok);
    total++; if (!ok) $display("FAIL filter_end: got no dump_end expected pulse"); else passed++;
    total++; if (first_diff() >= 0) $display("FAIL filter_stream: got %0d bytes expected %0d, first diff at %0d", cap_q.size(), exp_q.size(), first_diff()); else passed++;
    total++; if (records_sent !== 16'd2) $display("FAIL filter_records_sent: got %0d expected 2", records_sent); else passed++;
  endtask

  task automatic test_limit();
    bit ok;
    int e0;
    clear_streams();
    for (int i = 0; i < 5; i++) src_q.push_back({1'b0, 32'h0000_1000 + 32'(4 * i), 32'(i)});
    add_line("00001000 00000000 W");
    add_line("00001004 00000001 W");
    add_line("00001008 00000002 W");
    e0 = end_cnt;
    start_dump(1'b0, 32'h0, 32'h0, 16'd3, 1'b0);
    wait_end(300, ok);
    repeat (5) @(negedge clk);
    total++; if (!ok) $display("FAIL limit_end: got no dump_end expected pulse"); else passed++;
    total++; if (first_diff() >= 0) $display("FAIL limit_stream: got %0d bytes expected %0d, first diff at %0d", cap_q.size(), exp_q.size(), first_diff()); else passed++;
    total++; if (records_sent !== 16'd3) $display("FAIL limit_records_sent: got %0d expected 3", records_sent); else passed++;
    total++; if (src_q.size() !== 2) $display("FAIL limit_left: got %0d expected 2", src_q.size()); else passed++;
    total++; if (in_valid !== 1'b1) $display("FAIL limit_in_valid: got %b expected 1", in_valid); else passed++;
    total++; if (end_cnt - e0 !== 1) $display("FAIL limit_end_pulses: got %0d expected 1", end_cnt - e0); else passed++;
    src_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_streams();
    stall_cnt = 0;
    stall_err = 0;
    rdy_rand  = 1'b1;
    src_q.push_back({1'b0, 32'hFFFF_FFFF, 32'h0000_000A});
    src_q.push_back({1'b1, 32'h89AB_CDEF, 32'h0123_4567});
    add_line("FFFFFFFF 0000000A W");
    add_line("89ABCDEF 01234567 R");
    start_dump(1'b0, 32'h0, 32'h0, 16'd0, 1'b0);
    wait_end(1000, ok);
    rdy_rand = 1'b0;
    total++; if (!ok) $display("FAIL bp_end: got no dump_end expected pulse"); else passed++;
    total++; if (first_diff() >= 0) $display("FAIL bp_stream: got %0d bytes expected %0d, first diff at %0d", cap_q.size(), exp_q.size(), first_diff()); else passed++;
    total++; if (stall_err !== 0) $display("FAIL bp_stable: got %0d changes while stalled expected 0", stall_err); else passed++;
    total++; if (stall_cnt == 0) $display("FAIL bp_stalls: got %0d stall cycles expected >0", stall_cnt); else passed++;
    total++; if (records_sent !== 16'd2) $display("FAIL bp_records_sent: got %0d expected 2", records_sent); else passed++;
  endtask

  task automatic test_abort();
    bit ok;
    int n;
    clear_streams();
    src_q.push_back({1'b1, 32'h0000_0100, 32'h0000_0200});
    src_q.push_back({1'b0, 32'h0000_0104, 32'h0000_0204});
    src_q.push_back({1'b0, 32'h0000_0108, 32'h0000_0208});
    add_line("00000100 00000200 R");
    start_dump(1'b0, 32'h0, 32'h0, 16'd0, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++; if (!out_valid) $display("FAIL abort_first_byte: got out_valid=%b expected 1", out_valid); else passed++;
    repeat (3) @(negedge clk);
    dump_abort = 1'b1;
    @(negedge clk);
    dump_abort = 1'b0;
    wait_end(100, ok);
    total++; if (!ok) $display("FAIL abort_end: got no dump_end expected pulse"); else passed++;
    total++; if (first_diff() >= 0) $display("FAIL abort_stream: got %0d bytes expected %0d, first diff at %0d", cap_q.size(), exp_q.size(), first_diff()); else passed++;
    total++; if (records_sent !== 16'd1) $display("FAIL abort_records_sent: got %0d expected 1", records_sent); else passed++;
    total++; if (src_q.size() !== 2) $display("FAIL abort_left: got %0d expected 2", src_q.size()); else passed++;
    src_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_start_abort_same();
    bit ok;
    clear_streams();
    src_q.push_back({1'b0, 32'h0000_0010, 32'h0000_0020});
    add_line("00000010 00000020 W");
    start_dump(1'b0, 32'h0, 32'h0, 16'd0, 1'b1);
    wait_end(100, ok);
    total++; if (!ok) $display("FAIL sa_end: got no dump_end expected pulse"); else passed++;
    total++; if (first_diff() >= 0) $display("FAIL sa_stream: got %0d bytes expected %0d, first diff at %0d", cap_q.size(), exp_q.size(), first_diff()); else passed++;
    total++; if (records_sent !== 16'd1) $display("FAIL sa_records_sent: got %0d expected 1", records_sent); else passed++;
  endtask

  task automatic test_reset_mid();
    int n;
    int n0;
    clear_streams();
    src_q.push_back({1'b1, 32'hABCD_0123, 32'h4567_89EF});
    start_dump(1'b0, 32'h0, 32'h0, 16'd0, 1'b0);
    n = 0;
    while (cap_q.size() < 3 && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++; if (cap_q.size() < 3) $display("FAIL rst_mid_progress: got %0d bytes expected >=3", cap_q.size()); else passed++;
    reset = 1'b1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL rst_mid_drop: got out_valid=%b busy=%b expected 0/0", out_valid, busy); else passed++;
    total++; if (records_sent !== 16'd0) $display("FAIL rst_mid_count: got %0d expected 0", records_sent); else passed++;
    reset = 1'b0;
    n0 = cap_q.size();
    repeat (10) @(negedge clk);
    total++; if (cap_q.size() !== n0) $display("FAIL rst_mid_quiet: got %0d bytes expected %0d", cap_q.size(), n0); else passed++;
    src_q.delete();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    passed       = 0;
    total        = 0;
    cyc          = 0;
    end_cnt      = 0;
    rdy_rand     = 1'b0;
    reset        = 1'b1;
    dump_start   = 1'b0;
    dump_abort   = 1'b0;
    mode_raw     = 1'b0;
    filter_match = '0;
    filter_mask  = '0;
    max_records  = '0;
    test_reset();
    test_ascii();
    test_raw();
    test_filter();
    test_limit();
    test_back_to_back();
    test_abort();
    test_start_abort_same();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
